// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: bubble instruction, fetch FSM states,
// and the opcode constants used by both fetch and the Controller.
package cpu_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, KILL} fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: one request strobe per address,
// in-order responses with variable latency.
interface fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (output im_req, im_addr, input im_rvalid, im_rdata);
  modport slave  (input im_req, im_addr, output im_rvalid, im_rdata);
endinterface

// File: rtl/fetch_unit_hold_buf.sv
// fetch_hold_buf: single-entry {pc, inst, valid} register that parks a
// response arriving during a stall. Clear wins over load (redirect flush).
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // payload is qualified by valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (load) begin
      pc   <= pc_in;
      inst <= inst_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, keeps at most one imem request outstanding and fills
// the IF/ID register. Optional FETCH_PERF_CNT_EN adds fetch/kill counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         next_pc_sel,
  input  logic [31:0]  jb_pc,
  fetch_unit_if.master im,
  output logic [31:0]  D_pc,
  output logic [31:0]  D_inst,
  output logic         D_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_kill_cnt
`endif
);
  import cpu_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc, pc_plus4, redirect_pc;
  logic         deliver, drain, hb_load, hb_clear, hb_valid;
  logic [31:0]  hb_pc, hb_inst;

  assign pc_plus4    = pc_step(pc);
  assign redirect_pc = jb_pc & ~32'h3;

  // Request side: issued in the same cycle the previous slot frees up
  always_comb begin
    im.im_req  = 1'b0;
    im.im_addr = pc;
    deliver    = 1'b0;
    drain      = 1'b0;
    hb_load    = 1'b0;
    hb_clear   = next_pc_sel;
    if (!rst && !next_pc_sel) begin
      unique case (state)
        IDLE: im.im_req = !stall;
        WAIT: begin
          if (im.im_rvalid && !stall) begin
            im.im_req  = 1'b1;
            im.im_addr = pc_plus4;
            deliver    = 1'b1;
          end else if (im.im_rvalid) begin
            hb_load = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            im.im_req = 1'b1;
            drain     = 1'b1;
            hb_clear  = 1'b1;
          end
        end
        KILL: im.im_req = im.im_rvalid;
      endcase
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (hb_load),
    .clear   (hb_clear),
    .pc_in   (pc),
    .inst_in (im.im_rdata),
    .pc      (hb_pc),
    .inst    (hb_inst),
    .valid   (hb_valid)
  );

  // IF/ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      D_pc    <= 32'h0;
      D_inst  <= NOP_INST;
      D_valid <= 1'b0;
    end else if (next_pc_sel) begin
      pc      <= redirect_pc;
      D_inst  <= NOP_INST;
      D_valid <= 1'b0;
      state   <= ((state == WAIT || state == KILL) && !im.im_rvalid) ? KILL : IDLE;
    end else begin
      unique case (state)
        IDLE: if (!stall) state <= WAIT;
        WAIT: begin
          if (im.im_rvalid) begin
            pc <= pc_plus4;
            if (deliver) begin
              D_pc    <= pc;
              D_inst  <= im.im_rdata;
              D_valid <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (drain) begin
            D_pc    <= hb_pc;
            D_inst  <= hb_inst;
            D_valid <= hb_valid;
            state   <= WAIT;
          end
        end
        KILL: if (im.im_rvalid) state <= WAIT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_kill_cnt  <= 32'h0;
    end else begin
      if (deliver || drain) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (im.im_rvalid && (state == KILL || (next_pc_sel && state == WAIT)))
        perf_kill_cnt <= perf_kill_cnt + 32'd1;
    end
  end
`endif

  a_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(im.im_rvalid && (state == IDLE || state == HOLD)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized stall/redirect/
// latency traffic, checked against an outstanding-request queue model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, next_pc_sel;
  logic [31:0] jb_pc, D_pc, D_inst;
  logic        D_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_kill_cnt;
`endif

  fetch_unit_if im_bus ();

  fetch_unit #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .next_pc_sel (next_pc_sel),
    .jb_pc       (jb_pc),
    .im          (im_bus),
    .D_pc        (D_pc),
    .D_inst      (D_inst),
    .D_valid     (D_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory: one outstanding request, response after lat cycles
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_cfg = 1;
  bit          lat_rand = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  // Reference model: queue of in-flight fetches, each live or killed
  typedef struct {
    logic [31:0] addr;
    bit          live;
  } req_t;

  req_t        oq[$];
  logic [31:0] m_pc, m_dpc, m_dinst, m_hpc, m_hinst;
  bit          m_dvalid, m_held;
  int          m_fetch, m_kill;
  bit          s_req;
  logic [31:0] s_addr;

  task automatic model_reset();
    oq.delete();
    m_pc = 32'h0; m_dpc = 32'h0; m_dinst = NOP; m_dvalid = 0; m_held = 0;
    m_fetch = 0; m_kill = 0; mem_pend = 0; mem_cnt = 0;
  endtask

  task automatic step(input bit st, input bit nps, input logic [31:0] jb);
    bit          resp, live_r, dead_r, exp_req;
    req_t        e;
    logic [31:0] rdata;
    stall = st; next_pc_sel = nps; jb_pc = jb;
    resp  = mem_pend && (mem_cnt == 0);
    rdata = resp ? inst_of(mem_addr) : $urandom();
    im_bus.im_rvalid = resp;
    im_bus.im_rdata  = rdata;

    live_r = 0; dead_r = 0; exp_req = 0;
    e = '{addr: 32'h0, live: 1'b0};
    if (resp && oq.size() > 0) begin
      e = oq.pop_front();
      live_r = e.live;
      dead_r = !e.live;
    end
    if (resp && (dead_r || nps)) m_kill++;
    if (nps) begin
      m_pc = jb & ~32'h3; m_dinst = NOP; m_dvalid = 0; m_held = 0;
      foreach (oq[i]) oq[i].live = 1'b0;
    end else begin
      if (live_r) begin
        m_pc = e.addr + 32'd4;
        if (st) begin
          m_held = 1; m_hpc = e.addr; m_hinst = rdata;
        end else begin
          m_dpc = e.addr; m_dinst = rdata; m_dvalid = 1; m_fetch++;
        end
      end else if (m_held && !st) begin
        m_dpc = m_hpc; m_dinst = m_hinst; m_dvalid = 1; m_held = 0; m_fetch++;
      end
      exp_req = (oq.size() == 0) && (!st || dead_r);
      if (exp_req) oq.push_back('{addr: m_pc, live: 1'b1});
    end

    @(negedge clk);
    s_req  = im_bus.im_req;
    s_addr = im_bus.im_addr;
    chk("im_req", {31'b0, s_req}, {31'b0, exp_req});
    if (exp_req) chk("im_addr", s_addr, m_pc);

    if (resp) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (s_req) begin
      mem_pend = 1;
      mem_addr = s_addr;
      mem_cnt  = (lat_rand ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
    end

    @(posedge clk); #1;
    chk("D_pc", D_pc, m_dpc);
    chk("D_inst", D_inst, m_dinst);
    chk("D_valid", {31'b0, D_valid}, {31'b0, m_dvalid});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_kill", perf_kill_cnt, m_kill);
`endif
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    chk("rst_D_pc", D_pc, 32'h0);
    chk("rst_D_inst", D_inst, NOP);
    chk("rst_D_valid", {31'b0, D_valid}, 32'h0);
    chk("rst_im_req", {31'b0, im_bus.im_req}, 32'h0);
    im_bus.im_rvalid = 1'b0; stall = 1'b0; next_pc_sel = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; next_pc_sel = 1'b0; jb_pc = 32'h0;
    im_bus.im_rvalid = 1'b0; im_bus.im_rdata = 32'h0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_D_pc", D_pc, 32'h0);
    chk("reset_D_inst", D_inst, NOP);
    chk("reset_D_valid", {31'b0, D_valid}, 32'h0);
    chk("reset_im_req", {31'b0, im_bus.im_req}, 32'h0);
    rst = 1'b0;

    // back-to-back fetch with 1-cycle memory
    lat_cfg = 1;
    step(0, 0, 0); chk("t1_addr0", s_addr, 32'h0);
    step(0, 0, 0); chk("t1_addr4", s_addr, 32'h4);
    chk("t1_dpc0", D_pc, 32'h0); chk("t1_dvalid", {31'b0, D_valid}, 32'h1);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // response for 0x10 arrives during a 3-cycle stall
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("t2_noreq", {31'b0, s_req}, 32'h0);
    chk("t2_frozen_pc", D_pc, 32'hC);
    step(0, 0, 0);
    chk("t2_drain_pc", D_pc, 32'h10);
    chk("t2_next_addr", s_addr, 32'h14);

    // redirect while 0x20 is outstanding with 3-cycle latency
    lat_cfg = 3;
    n = 0;
    while (!(s_req && s_addr == 32'h20) && n < 20) begin step(0, 0, 0); n++; end
    chk("t3_reach_20", s_addr, 32'h20);
    step(0, 1, 32'h103);
    chk("t3_flush_inst", D_inst, NOP);
    chk("t3_flush_valid", {31'b0, D_valid}, 32'h0);
    n = 0;
    step(0, 0, 0);
    while (!s_req && n < 6) begin step(0, 0, 0); n++; end
    chk("t3_redirect_req", {31'b0, s_req}, 32'h1);
    chk("t3_redirect_addr", s_addr, 32'h100);

    // redirect and stall together on a response cycle
    lat_cfg = 1;
    n = 0;
    while (!(mem_pend && mem_cnt == 0) && n < 6) begin step(0, 0, 0); n++; end
    step(1, 1, 32'h200);
    chk("t4_noreq", {31'b0, s_req}, 32'h0);
    step(0, 0, 0);
    chk("t4_req", {31'b0, s_req}, 32'h1);
    chk("t4_addr", s_addr, 32'h200);

    // reset with a request outstanding, then restart
    reset_mid();
    step(0, 0, 0);
    chk("t5_restart", s_addr, 32'h0);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0); chk("t6_top", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0); chk("t6_wrap", s_addr, 32'h0);
    chk("t6_dpc", D_pc, 32'hFFFF_FFFC);

    // randomized traffic
    lat_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] jb;
      jb = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : ($urandom() & 32'h0000_0FFF);
      if ($urandom_range(0, 499) == 0) reset_mid();
      step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 7, jb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
IF stage of the 5-stage RV32I pipeline.
- Owns the PC and issues in-order instruction-memory requests with at most one outstanding, against variable latency (≥1 cycle).
- Delivers {instruction, PC} through the IF/ID register to the decoder/Controller.
- Obeys Controller `stall` (hold) and `next_pc_sel` (flush and redirect to `jb_pc`).

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) presented to ID when no valid instruction.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  load-use stall from Controller; hold PC and IF/ID.
- next_pc_sel  in  1  taken branch/jump resolved in EXE; flush and redirect.
- jb_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- im_req  out  1  request strobe, one cycle per request (combinational).
- im_addr  out  32  request address, word aligned (combinational).
- im_rvalid  in  1  response valid; responses return in request order.
- im_rdata  in  32  response instruction.
- D_pc  out  32  PC of instruction in IF/ID.
- D_inst  out  32  instruction in IF/ID (NOP_INST when !D_valid).
- D_valid  out  1  IF/ID holds a real instruction.

Behaviour:
Reset values (async, immediate):
- pc = RESET_PC, state = IDLE, buf_valid = 0.
- D_pc = 0, D_inst = NOP_INST, D_valid = 0, im_req = 0.

States:
- IDLE: no request outstanding. In IDLE with !stall, im_req = 1, im_addr = pc, next state WAIT. First request is issued in the first cycle after rst deasserts.
- WAIT: one request outstanding for address `pc`.
- HOLD: response captured in the single-entry hold buffer while stalled; no request outstanding.
- KILL: outstanding request belongs to a flushed path; its response is discarded.

Priority per cycle: rst > next_pc_sel > stall > normal flow.

next_pc_sel = 1 (any state):
- pc <= {jb_pc[31:2], 2'b00}; IF/ID <= {D_pc unchanged, NOP_INST, D_valid = 0}; buf_valid <= 0.
- WAIT without im_rvalid this cycle -> KILL.
- WAIT with im_rvalid this cycle, IDLE, or HOLD -> IDLE; response dropped.
- KILL without im_rvalid stays KILL.
- No request is issued in a redirect cycle.

KILL:
- On im_rvalid, discard the response, then same cycle im_req = 1, im_addr = pc, next state WAIT.

WAIT, im_rvalid, !stall (the normal flow):
- IF/ID <= {pc, im_rdata, 1}; pc <= pc + 4.
- Same cycle im_req = 1, im_addr = pc + 4; stay WAIT.
- Throughput is 1 instruction/cycle with 1-cycle memory.

WAIT, im_rvalid, stall:
- Capture {pc, im_rdata} into the hold buffer; pc <= pc + 4; next state HOLD; IF/ID unchanged.

HOLD with !stall:
- IF/ID <= buffer; buf_valid <= 0.
- Same cycle im_req = 1, im_addr = pc; next state WAIT.

WAIT/IDLE with stall and no response: IF/ID and pc hold; IDLE issues no request.

PC arithmetic: 32-bit, wraps at 32'hFFFF_FFFC -> 0 without flag.

im_rvalid while IDLE or HOLD is a protocol error and is ignored; an assertion fires in simulation.

Optional Feature:
FETCH_PERF_CNT_EN:
- When defined, adds outputs perf_fetch_cnt[31:0] (responses delivered to IF/ID) and perf_kill_cnt[31:0] (responses discarded in KILL or in a redirect cycle).
- Both counters reset to 0 and wrap.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
Shared package cpu_pkg holds:
- NOP_INST constant;
- fetch state enum {IDLE, WAIT, HOLD, KILL};
- the opcode constants already shared with the Controller.

One sub-module is natural: fetch_hold_buf, the single-entry {pc, inst, valid} holding register with load/clear/drain.

Test Plan:
1. Reset release with RESET_PC = 0 and 1-cycle memory -> im_addr 0,4,8,… on consecutive cycles; D_pc follows one cycle later with D_valid = 1.
2. Stall for 3 cycles while the response for 0x10 arrives -> state HOLD, no im_req, D_* frozen. The cycle stall drops: D_pc = 0x10, im_addr = 0x14.
3. next_pc_sel with jb_pc = 0x103, request to 0x20 outstanding (3-cycle latency) -> next cycle D_inst = 0x13, D_valid = 0. The 0x20 response is discarded, then im_addr = 0x100 the same cycle.
4. next_pc_sel and stall together with im_rvalid -> redirect wins: response dropped, state IDLE, next cycle im_addr = jb_pc.
5. rst asserted mid-WAIT -> outputs return to reset values immediately; fetch restarts at RESET_PC after deassert.
6. PC = 0xFFFF_FFFC fetched -> next im_addr = 0x0000_0000; with FETCH_PERF_CNT_EN, perf_fetch_cnt increments by 1 per delivered instruction and perf_kill_cnt equals the count of discarded responses.
